control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 150 +++++++++++++++
 tb/tb_control_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Multi-cycle control unit: FETCH/EXEC/MEM/HALT sequencer driving a 16-bit datapath.
// Define CU_BRANCH_EN to enable BEQ/JMP/JAL/JR; otherwise those opcodes are NOPs.
module control_sequencer #(
  parameter logic [3:0] FS_ADD   = 4'h2,
  parameter logic [3:0] FS_SUB   = 4'h5,
  parameter logic [3:0] FS_AND   = 4'h8,
  parameter logic [3:0] FS_OR    = 4'h9,
  parameter logic [3:0] FS_XOR   = 4'hA,
  parameter logic [3:0] FS_PASSB = 4'hC
) (
  input  logic        clk_main,
  input  logic        reset,
  input  logic [15:0] InstrIn,
  input  logic        Z,
  input  logic [15:0] BusA,
  output logic [5:0]  PC,
  output logic [3:0]  DR,
  output logic [3:0]  SA,
  output logic [3:0]  SB,
  output logic [3:0]  FS,
  output logic        MB,
  output logic        MD,
  output logic        RW,
  output logic        MP,
  output logic        MW,
  output logic        Halted
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_e;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_LDI = 4'h6;
  localparam logic [3:0] OP_LD  = 4'h7;
  localparam logic [3:0] OP_ST  = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;
`ifdef CU_BRANCH_EN
  localparam logic [3:0] OP_BEQ = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_JAL = 4'hB;
  localparam logic [3:0] OP_JR  = 4'hC;
`endif

  state_e      state_q, state_d;
  logic [5:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [3:0]  op;

  assign op = ir_q[15:12];

`ifdef CU_BRANCH_EN
  logic signed [5:0] br_off;
  logic              unused_busa;
  assign br_off      = {{2{ir_q[11]}}, ir_q[11:8]};
  assign unused_busa = ^BusA[15:6];
`else
  logic unused_inputs;
  assign unused_inputs = ^{Z, BusA};
`endif

  always_ff @(posedge clk_main) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= 6'd0;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      FETCH: begin
        ir_d    = InstrIn;
        pc_d    = pc_q + 6'd1;
        state_d = EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        case (op)
          OP_LD:  state_d = MEM;
          OP_HLT: state_d = HALT;
`ifdef CU_BRANCH_EN
          // pc_q already points past the branch, so the offset is relative to PC+1
          OP_BEQ: if (Z) pc_d = pc_q + br_off;
          OP_JMP: pc_d = ir_q[5:0];
          OP_JAL: pc_d = ir_q[5:0];
          OP_JR:  pc_d = BusA[5:0];
`endif
          default: ;
        endcase
      end
      MEM:     state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    PC     = pc_q;
    DR     = ir_q[11:8];
    SA     = ir_q[7:4];
    SB     = ir_q[3:0];
    FS     = 4'h0;
    MB     = 1'b0;
    MD     = 1'b0;
    RW     = 1'b0;
    MP     = 1'b0;
    MW     = 1'b0;
    Halted = (state_q == HALT);
    if (state_q == EXEC) begin
      case (op)
        OP_ADD: begin FS = FS_ADD; RW = 1'b1; end
        OP_SUB: begin FS = FS_SUB; RW = 1'b1; end
        OP_AND: begin FS = FS_AND; RW = 1'b1; end
        OP_OR:  begin FS = FS_OR;  RW = 1'b1; end
        OP_XOR: begin FS = FS_XOR; RW = 1'b1; end
        OP_LDI: begin FS = FS_PASSB; MB = 1'b1; RW = 1'b1; end
        OP_ST:  MW = 1'b1;
`ifdef CU_BRANCH_EN
        OP_BEQ: FS = FS_SUB;
        OP_JAL: begin MP = 1'b1; RW = 1'b1; end
`endif
        default: ;
      endcase
    end else if (state_q == MEM) begin
      MD = 1'b1;
      RW = 1'b1;
    end
    // Strobes are suppressed during reset so the aborting edge writes nothing
    if (reset) begin
      FS     = 4'h0;
      MB     = 1'b0;
      MD     = 1'b0;
      RW     = 1'b0;
      MP     = 1'b0;
      MW     = 1'b0;
      Halted = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: an instruction-level model queues per-cycle
// expected outputs; a negedge monitor pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_control_sequencer;
  localparam logic [3:0] FS_ADD   = 4'h2;
  localparam logic [3:0] FS_SUB   = 4'h5;
  localparam logic [3:0] FS_AND   = 4'h8;
  localparam logic [3:0] FS_OR    = 4'h9;
  localparam logic [3:0] FS_XOR   = 4'hA;
  localparam logic [3:0] FS_PASSB = 4'hC;
  localparam logic [27:0] M_ALL = 28'hFFFFFFF;
  localparam logic [27:0] M_STB = 28'h00003FF;

  logic clk_main = 1'b0;
  always #5 clk_main = ~clk_main;

  logic        reset;
  logic [15:0] InstrIn, BusA;
  logic        Z;
  logic [5:0]  PC;
  logic [3:0]  DR, SA, SB, FS;
  logic        MB, MD, RW, MP, MW, Halted;

  control_sequencer #(
    .FS_ADD(FS_ADD), .FS_SUB(FS_SUB), .FS_AND(FS_AND),
    .FS_OR(FS_OR), .FS_XOR(FS_XOR), .FS_PASSB(FS_PASSB)
  ) dut (
    .clk_main(clk_main), .reset(reset), .InstrIn(InstrIn), .Z(Z), .BusA(BusA),
    .PC(PC), .DR(DR), .SA(SA), .SB(SB), .FS(FS),
    .MB(MB), .MD(MD), .RW(RW), .MP(MP), .MW(MW), .Halted(Halted)
  );

  typedef struct {
    logic [27:0] v;
    logic [27:0] m;
    string       tag;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] mem [64];
  logic [5:0]  m_pc = 6'd0;
  logic [15:0] m_ir = 16'h0;
  int          zmode = -1;
  int          n_instr = 0;
  logic [5:0]  halt_pc;

  function automatic logic [27:0] pk(input logic [5:0] pc, input logic [15:0] ir,
                                     input logic [3:0] fs, input logic mb, input logic md,
                                     input logic rw, input logic mp, input logic mw,
                                     input logic h);
    return {pc, ir[11:8], ir[7:4], ir[3:0], fs, mb, md, rw, mp, mw, h};
  endfunction

  always @(negedge clk_main) begin : monitor
    exp_t e;
    logic [27:0] act;
    if (q.size() > 0) begin
      e = q.pop_front();
      act = pk(PC, {4'h0, DR, SA, SB}, FS, MB, MD, RW, MP, MW, Halted);
      vectors++;
      if ((act & e.m) !== (e.v & e.m)) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h (mask %h)", e.tag, act, e.v, e.m);
      end
    end
  end

  task automatic check_direct(input logic [5:0] exp_pc, input logic exp_halted,
                              input string tag);
    vectors++;
    if (PC !== exp_pc || Halted !== exp_halted) begin
      miscompares++;
      $display("FAIL %s: PC=%0d Halted=%b expected PC=%0d Halted=%b",
               tag, PC, Halted, exp_pc, exp_halted);
    end
  endtask

  task automatic step(input logic [27:0] v, input logic [27:0] m, input string tag);
    exp_t e;
    e.v = v; e.m = m; e.tag = tag;
    q.push_back(e);
    @(posedge clk_main);
    #1;
  endtask

  task automatic drive();
    Z       = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
    BusA    = 16'($urandom);
    InstrIn = mem[m_pc];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive();
    step(pk(6'd0, 16'h0, 4'h0, 0, 0, 0, 0, 0, 0), M_STB, "reset_strobes");
    drive();
    step(pk(6'd0, 16'h0, 4'h0, 0, 0, 0, 0, 0, 0), M_ALL, "reset_state");
    reset = 1'b0;
    m_pc = 6'd0;
    m_ir = 16'h0;
  endtask

  // One instruction at ISA level: FETCH cycle, EXEC cycle, optional MEM cycle.
  task automatic run_instr(input bit abort_mem);
    logic [3:0] fs, op;
    logic       mb, md, rw, mp, mw;
    logic [5:0] npc;
    int         off;
    drive();
    step(pk(m_pc, m_ir, 4'h0, 0, 0, 0, 0, 0, 0), M_ALL,
         $sformatf("i%0d_fetch_pc%0d", n_instr, m_pc));
    m_ir = mem[m_pc];
    m_pc = 6'((int'(m_pc) + 1) % 64);
    op = m_ir[15:12];
    fs = 4'h0; mb = 0; md = 0; rw = 0; mp = 0; mw = 0;
    npc = m_pc;
    drive();
    case (op)
      4'h1: begin fs = FS_ADD; rw = 1; end
      4'h2: begin fs = FS_SUB; rw = 1; end
      4'h3: begin fs = FS_AND; rw = 1; end
      4'h4: begin fs = FS_OR;  rw = 1; end
      4'h5: begin fs = FS_XOR; rw = 1; end
      4'h6: begin fs = FS_PASSB; mb = 1; rw = 1; end
      4'h8: mw = 1;
`ifdef CU_BRANCH_EN
      4'h9: begin
        fs = FS_SUB;
        off = m_ir[11] ? int'(m_ir[11:8]) - 16 : int'(m_ir[11:8]);
        if (Z) npc = 6'((int'(m_pc) + off + 64) % 64);
      end
      4'hA: npc = m_ir[5:0];
      4'hB: begin mp = 1; rw = 1; npc = m_ir[5:0]; end
      4'hC: npc = 6'(BusA % 16'd64);
`endif
      default: ;
    endcase
    step(pk(m_pc, m_ir, fs, mb, md, rw, mp, mw, 0), M_ALL,
         $sformatf("i%0d_exec_op%h", n_instr, op));
    m_pc = npc;
    if (op == 4'h7) begin
      if (abort_mem) begin
        reset = 1'b1;
        drive();
        step(pk(6'd0, 16'h0, 4'h0, 0, 0, 0, 0, 0, 0), M_STB,
             $sformatf("i%0d_mem_reset", n_instr));
        reset = 1'b0;
        m_pc = 6'd0;
        m_ir = 16'h0;
        check_direct(6'd0, 1'b0, "mem_abort_state");
      end else begin
        drive();
        step(pk(m_pc, m_ir, 4'h0, 0, 1, 1, 0, 0, 0), M_ALL,
             $sformatf("i%0d_mem", n_instr));
      end
    end
    n_instr++;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++)
      mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
  endtask

  initial begin
    reset = 1'b1; Z = 1'b0; BusA = 16'h0; InstrIn = 16'h0;
    fill_random();
    mem[0] = 16'h6312; mem[1] = 16'h7450; mem[2] = 16'h8123; mem[3] = 16'h1123;
    mem[4] = 16'h0000; mem[5] = 16'h9E12; mem[6] = 16'hD000; mem[7] = 16'hE000;
    mem[8] = 16'h5AB3; mem[9] = 16'h2456; mem[10] = 16'hB02A;
    mem[6'h2A] = 16'hA03F; mem[63] = 16'h0000;
    @(posedge clk_main);
    #1;
    do_reset();
    check_direct(6'd0, 1'b0, "reset_direct_initial");

    for (int i = 0; i < 5; i++) run_instr(0);
    zmode = 1;
    run_instr(0);
    zmode = 0;
    for (int k = 0; k < 4 && m_pc != 6'd6; k++) run_instr(0);
    zmode = -1;
    for (int i = 0; i < 4; i++) run_instr(0);
    run_instr(0);
    for (int k = 0; k < 80 && m_pc != 6'd0; k++) run_instr(0);

    fill_random();
    for (int i = 0; i < 150; i++) run_instr(0);

    mem[m_pc] = 16'hF000;
    run_instr(0);
    halt_pc = m_pc;
    for (int i = 0; i < 20; i++) begin
      drive();
      step(pk(m_pc, m_ir, 4'h0, 0, 0, 0, 0, 0, 1), M_ALL, $sformatf("halt_c%0d", i));
      check_direct(halt_pc, 1'b1, $sformatf("halt_hold_c%0d", i));
    end
    check_direct(halt_pc, 1'b1, "halt_wait_expired");
    do_reset();
    check_direct(6'd0, 1'b0, "reset_direct_after_halt");

    mem[0] = 16'h7450;
    run_instr(1);
    run_instr(0);
    run_instr(0);

    if (miscompares != 0)
      $display("FAIL summary: %0d miscompares", miscompares);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
